// File: rtl/l2_line_responder.sv
// L2-side line responder: services L1D refills and writebacks from an on-chip
// line array with a fixed access latency, one request outstanding at a time.
module l2_line_responder #(
    parameter int LINE_BITS   = 128,
    parameter int OFFSET_BITS = 4,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 l1_l2_req_valid,
    input  logic                 l1_l2_req_write,
    input  logic [31:0]          l1_l2_req_addr,
    input  logic [LINE_BITS-1:0] l1_l2_req_wdata,
    output logic                 l2_l1_req_ready,
    output logic                 l2_l1_resp_valid,
    output logic [LINE_BITS-1:0] l2_l1_resp_rdata,
    output logic                 l2_l1_resp_err,
    input  logic                 l1_l2_resp_ready
);
    localparam int IDX_BITS = $clog2(DEPTH_LINES);
    localparam int TAG_LSB  = OFFSET_BITS + IDX_BITS;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 write_q, write_d;
    logic                 oor_q, oor_d;
    logic [IDX_BITS-1:0]  idx_q, idx_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 mem_we;
    logic                 unused_offset;

    logic [LINE_BITS-1:0] mem [DEPTH_LINES];

    // Offset bits select a byte within the line and play no part here.
    assign unused_offset = ^l1_l2_req_addr[OFFSET_BITS-1:0];

    assign l2_l1_resp_valid = (state_q == RESP);
    assign l2_l1_resp_rdata = rdata_q;
    assign l2_l1_resp_err   = err_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        write_d         = write_q;
        oor_d           = oor_q;
        idx_d           = idx_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        err_d           = err_q;
        mem_we          = 1'b0;
        l2_l1_req_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                l2_l1_req_ready = 1'b1;
                if (l1_l2_req_valid) begin
                    write_d = l1_l2_req_write;
                    oor_d   = |l1_l2_req_addr[31:TAG_LSB];
                    idx_d   = l1_l2_req_addr[OFFSET_BITS +: IDX_BITS];
                    wdata_d = l1_l2_req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    err_d   = oor_q;
                    rdata_d = (write_q || oor_q) ? '0 : mem[idx_q];
                    mem_we  = write_q && !oor_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (l1_l2_resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            write_q <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            oor_q   <= oor_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; a reset during WAIT leaves state_q in IDLE, so no write lands.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_l2_line_responder.sv
// Directed bench for l2_line_responder: one LATENCY=4 instance for the
// functional scenarios and one LATENCY=1 instance for throughput.
module tb_l2_line_responder;
    localparam int LB = 128;
    localparam logic [LB-1:0] PAT_DB = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [LB-1:0] PAT_Z0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [LB-1:0] PAT_X  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    localparam logic [LB-1:0] PAT_A  = 128'hAAAA_0000_AAAA_0000_AAAA_0000_AAAA_0080;
    localparam logic [LB-1:0] PAT_B  = 128'hBBBB_1111_BBBB_1111_BBBB_1111_BBBB_0080;
    localparam logic [LB-1:0] PAT_D1 = 128'h1111_1111_0000_0000_1111_1111_0000_0010;
    localparam logic [LB-1:0] PAT_D2 = 128'h2222_2222_0000_0000_2222_2222_0000_0020;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_vld = 0, a_wr = 0, a_rr = 1;
    logic [31:0]   a_addr = '0;
    logic [LB-1:0] a_wd = '0;
    logic          a_rdy, a_rv, a_err;
    logic [LB-1:0] a_rd;

    logic          b_vld = 0, b_wr = 0, b_rr = 1;
    logic [31:0]   b_addr = '0;
    logic [LB-1:0] b_wd = '0;
    logic          b_rdy, b_rv, b_err;
    logic [LB-1:0] b_rd;

    int n_tests = 0;
    int n_fail  = 0;

    l2_line_responder #(.LINE_BITS(LB), .OFFSET_BITS(4), .DEPTH_LINES(1024), .LATENCY(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .l1_l2_req_valid(a_vld), .l1_l2_req_write(a_wr),
        .l1_l2_req_addr(a_addr), .l1_l2_req_wdata(a_wd),
        .l2_l1_req_ready(a_rdy), .l2_l1_resp_valid(a_rv),
        .l2_l1_resp_rdata(a_rd), .l2_l1_resp_err(a_err),
        .l1_l2_resp_ready(a_rr)
    );

    l2_line_responder #(.LINE_BITS(LB), .OFFSET_BITS(4), .DEPTH_LINES(1024), .LATENCY(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .l1_l2_req_valid(b_vld), .l1_l2_req_write(b_wr),
        .l1_l2_req_addr(b_addr), .l1_l2_req_wdata(b_wd),
        .l2_l1_req_ready(b_rdy), .l2_l1_resp_valid(b_rv),
        .l2_l1_resp_rdata(b_rd), .l2_l1_resp_err(b_err),
        .l1_l2_resp_ready(b_rr)
    );

    // Drives one request on instance A with resp_ready=1 and reports what came back.
    task automatic xact(input logic wr, input logic [31:0] addr, input logic [LB-1:0] wd,
                        output int lat, output logic [LB-1:0] rd, output logic er,
                        output logic rv_after, output logic rdy_after);
        @(negedge clk);
        a_vld = 1; a_wr = wr; a_addr = addr; a_wd = wd; a_rr = 1;
        @(posedge clk);
        @(negedge clk);
        a_vld = 0; a_wr = ~wr; a_addr = 32'hFFFF_FFFF; a_wd = ~wd;
        lat = 0;
        while (!a_rv && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = a_rd;
        er = a_err;
        @(negedge clk);
        rv_after  = a_rv;
        rdy_after = a_rdy;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        #1;
        n_tests++;
        if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", a_rdy); end
        n_tests++;
        if (a_rv !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", a_rv); end
        n_tests++;
        if (a_rd !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", a_rd); end
        n_tests++;
        if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", a_err); end
        n_tests++;
        if (b_rdy !== 1'b1 || b_rv !== 1'b0) begin
            n_fail++; $display("FAIL reset_b got rdy=%b rv=%b exp rdy=1 rv=0", b_rdy, b_rv);
        end
    endtask

    task automatic test_write_read();
        int lat; logic [LB-1:0] rd; logic er, rva, rdya;
        xact(1'b1, 32'h0000_0040, PAT_DB, lat, rd, er, rva, rdya);
        n_tests++;
        if (lat !== 4) begin n_fail++; $display("FAIL wr_latency got=%0d exp=4", lat); end
        n_tests++;
        if (rd !== '0 || er !== 1'b0) begin
            n_fail++; $display("FAIL wr_ack got rdata=%h err=%b exp 0/0", rd, er);
        end
        n_tests++;
        if (rva !== 1'b0 || rdya !== 1'b1) begin
            n_fail++; $display("FAIL wr_handshake got rv=%b rdy=%b exp 0/1", rva, rdya);
        end
        xact(1'b0, 32'h0000_004C, '0, lat, rd, er, rva, rdya);
        n_tests++;
        if (lat !== 4) begin n_fail++; $display("FAIL rd_latency got=%0d exp=4", lat); end
        n_tests++;
        if (rd !== PAT_DB || er !== 1'b0) begin
            n_fail++; $display("FAIL rd_data got=%h err=%b exp=%h err=0", rd, er, PAT_DB);
        end
        n_tests++;
        if (rva !== 1'b0) begin n_fail++; $display("FAIL rd_clear got rv=%b exp=0", rva); end
    endtask

    task automatic test_backpressure();
        int lat; logic [LB-1:0] rd0, rd; logic er0, er, rva, rdya;
        int bad;
        @(negedge clk);
        a_vld = 1; a_wr = 0; a_addr = 32'h0000_0040; a_rr = 0;
        @(posedge clk);
        @(negedge clk);
        a_vld = 0;
        lat = 0;
        while (!a_rv && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd0 = a_rd;
        er0 = a_err;
        n_tests++;
        if (lat !== 4 || rd0 !== PAT_DB || er0 !== 1'b0) begin
            n_fail++; $display("FAIL bp_first got lat=%0d rdata=%h err=%b exp 4/%h/0", lat, rd0, er0, PAT_DB);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_rv !== 1'b1 || a_rd !== rd0 || a_err !== er0 || a_rdy !== 1'b0) bad++;
            if (i == 3) begin
                a_vld = 1; a_wr = 1; a_addr = 32'h0000_0040; a_wd = PAT_X;
            end else begin
                a_vld = 0;
            end
            @(negedge clk);
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable cycles exp=0", bad); end
        a_rr = 1;
        @(negedge clk);
        n_tests++;
        if (a_rv !== 1'b0 || a_rdy !== 1'b1 || a_rd !== '0) begin
            n_fail++; $display("FAIL bp_release got rv=%b rdy=%b rdata=%h exp 0/1/0", a_rv, a_rdy, a_rd);
        end
        xact(1'b0, 32'h0000_0040, '0, lat, rd, er, rva, rdya);
        n_tests++;
        if (rd !== PAT_DB) begin n_fail++; $display("FAIL bp_pulse_ignored got=%h exp=%h", rd, PAT_DB); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [LB-1:0] rd; logic er, rva, rdya;
        xact(1'b1, 32'h0000_0000, PAT_Z0, lat, rd, er, rva, rdya);
        xact(1'b0, 32'h0001_0000, '0, lat, rd, er, rva, rdya);
        n_tests++;
        if (er !== 1'b1 || rd !== '0 || lat !== 4) begin
            n_fail++; $display("FAIL oor_read got err=%b rdata=%h lat=%0d exp 1/0/4", er, rd, lat);
        end
        xact(1'b1, 32'h8000_0000, PAT_X, lat, rd, er, rva, rdya);
        n_tests++;
        if (er !== 1'b1 || rd !== '0) begin
            n_fail++; $display("FAIL oor_write got err=%b rdata=%h exp 1/0", er, rd);
        end
        xact(1'b0, 32'h0000_0000, '0, lat, rd, er, rva, rdya);
        n_tests++;
        if (rd !== PAT_Z0 || er !== 1'b0) begin
            n_fail++; $display("FAIL oor_idx0_intact got=%h err=%b exp=%h err=0", rd, er, PAT_Z0);
        end
        xact(1'b0, 32'h0000_3FF0, '0, lat, rd, er, rva, rdya);
        n_tests++;
        if (er !== 1'b0) begin n_fail++; $display("FAIL top_idx_in_range got err=%b exp=0", er); end
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic [LB-1:0] rd; logic er, rva, rdya;
        int seen;
        xact(1'b1, 32'h0000_0080, PAT_A, lat, rd, er, rva, rdya);
        @(negedge clk);
        a_vld = 1; a_wr = 1; a_addr = 32'h0000_0080; a_wd = PAT_B;
        @(posedge clk);
        @(negedge clk);
        a_vld = 0;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        n_tests++;
        if (a_rv !== 1'b0 || a_rdy !== 1'b1) begin
            n_fail++; $display("FAIL rst_in_reset got rv=%b rdy=%b exp 0/1", a_rv, a_rdy);
        end
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_rv) seen++;
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL rst_no_resp got %0d valid cycles exp=0", seen); end
        xact(1'b0, 32'h0000_0080, '0, lat, rd, er, rva, rdya);
        n_tests++;
        if (rd !== PAT_A) begin n_fail++; $display("FAIL rst_write_dropped got=%h exp=%h", rd, PAT_A); end
    endtask

    task automatic test_back_to_back();
        logic          q_wr [4];
        logic [31:0]   q_ad [4];
        logic [LB-1:0] q_wd [4];
        logic [LB-1:0] exp_rd [4];
        int acc [$];
        logic [LB-1:0] rsp [$];
        int i;
        q_wr = '{1'b1, 1'b1, 1'b0, 1'b0};
        q_ad = '{32'h10, 32'h20, 32'h1C, 32'h24};
        q_wd = '{PAT_D1, PAT_D2, PAT_X, PAT_X};
        exp_rd = '{'0, '0, PAT_D1, PAT_D2};
        i = 0;
        b_rr = 1;
        for (int cyc = 0; cyc < 60 && rsp.size() < 4; cyc++) begin
            @(negedge clk);
            if (b_rv) rsp.push_back(b_rd);
            if (i < 4) begin
                b_vld = 1; b_wr = q_wr[i]; b_addr = q_ad[i]; b_wd = q_wd[i];
                if (b_rdy) begin
                    acc.push_back(cyc);
                    i++;
                end
            end else begin
                b_vld = 0;
            end
        end
        b_vld = 0;
        n_tests++;
        if (rsp.size() !== 4 || acc.size() !== 4) begin
            n_fail++; $display("FAIL b2b_count got rsp=%0d acc=%0d exp 4/4", rsp.size(), acc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (acc[k+1] - acc[k] !== 3) begin
                    n_fail++; $display("FAIL b2b_spacing_%0d got=%0d exp=3", k, acc[k+1] - acc[k]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (rsp[k] !== exp_rd[k]) begin
                    n_fail++; $display("FAIL b2b_resp_%0d got=%h exp=%h", k, rsp[k], exp_rd[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_wait();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
